// File: rtl/regfile_onehot_wr_pkg.sv
// Shared types and the one-hot helper used by the write decoder and by
// reference models.
package regfile_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int MAX_AW = 8;
  localparam int MAX_N  = 2 ** MAX_AW;

  typedef logic [AW_DEF-1:0] addr_t;
  typedef logic [DW_DEF-1:0] data_t;

  // Callers narrower than MAX_AW zero-extend the address and truncate the result.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_AW-1:0] addr);
    logic [MAX_N-1:0] r;
    r       = {MAX_N{1'b0}};
    r[addr] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regfile_onehot_wr_decoder.sv
// Parametrised AW-to-2**AW one-hot decoder with enable, purely combinational.
module decoder_n
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              en,
  input  logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  sel
);

  localparam int N = 2 ** AW;

  // Decode the address into a single row select when enabled.
  always_comb begin
    sel = {N{1'b0}};
    if (en) begin
      sel = N'(onehot(MAX_AW'(addr)));
    end else begin
      sel = {N{1'b0}};
    end
  end

endmodule

// File: rtl/regfile_onehot_wr.sv
// 2**AW x DW register bank: one one-hot decoded write port, two registered
// read ports with optional same-edge write-through bypass and hardwired zero row.
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DW-1:0]     rdata_a,
  output logic [DW-1:0]     rdata_b,
  output logic [2**AW-1:0]  wsel
);

  localparam int NREGS = 2 ** AW;

  logic [NREGS-1:0]         dec_sel_s;
  logic [NREGS-1:0][DW-1:0] rows_s;
  logic [DW-1:0]            rdata_a_d, rdata_a_q;
  logic [DW-1:0]            rdata_b_d, rdata_b_q;

  decoder_n #(.AW(AW)) u_dec (
    .en   (we),
    .addr (waddr),
    .sel  (dec_sel_s)
  );

  // Row 0 never gets a write strobe when it is the hardwired zero register.
  always_comb begin
    wsel = dec_sel_s;
    if (ZERO_REG != 0) begin
      wsel[0] = 1'b0;
    end else begin
      wsel[0] = dec_sel_s[0];
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_row
    logic [DW-1:0] row_d, row_q;

    // Next row content: load wdata when this row is selected.
    always_comb begin
      if (wsel[i]) begin
        row_d = wdata;
      end else begin
        row_d = row_q;
      end
    end

    // Row storage; reset wins over any coincident write.
    always_ff @(posedge clk) begin
      if (rst) begin
        row_q <= {DW{1'b0}};
      end else begin
        row_q <= row_d;
      end
    end

    assign rows_s[i] = row_q;
  end

  // Zero row first, then same-edge forwarding, then stored (pre-write) content.
  function automatic logic [DW-1:0] read_value(
    input logic [AW-1:0] ra,
    input logic [DW-1:0] stored,
    input logic          w_en,
    input logic [AW-1:0] w_addr,
    input logic [DW-1:0] w_data
  );
    logic [DW-1:0] v;
    if ((ZERO_REG != 0) && (ra == {AW{1'b0}})) begin
      v = {DW{1'b0}};
    end else if ((BYPASS != 0) && w_en && (w_addr == ra)) begin
      v = w_data;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Read muxes; outputs hold while re is low.
  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (re) begin
      rdata_a_d = read_value(raddr_a, rows_s[raddr_a], we, waddr, wdata);
      rdata_b_d = read_value(raddr_b, rows_s[raddr_b], we, waddr, wdata);
    end else begin
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a_q <= {DW{1'b0}};
      rdata_b_q <= {DW{1'b0}};
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Scoreboard bench for regfile_onehot_wr: stimulus pushes expected read data,
// a negedge monitor pops and compares each registered output cycle.
module tb_regfile_onehot_wr;
  import regfile_pkg::*;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int ZERO_REG = 1;
  localparam int BYPASS   = 1;
  localparam int NREGS    = 2 ** AW;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic              re = 1'b0;
  logic [AW-1:0]     raddr_a = '0;
  logic [AW-1:0]     raddr_b = '0;
  logic [DW-1:0]     rdata_a;
  logic [DW-1:0]     rdata_b;
  logic [NREGS-1:0]  wsel;

  exp_t          exp_q[$];
  logic [DW-1:0] mem_m [NREGS];
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;
  logic          issue  = 1'b0;
  logic          rd_vld = 1'b0;
  int            n_cmp  = 0;
  int            n_bad  = 0;

  regfile_onehot_wr #(
    .AW(AW), .DW(DW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (re),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .wsel    (wsel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= issue;

  // Monitor: one expected pair per captured cycle.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow t=%0t: output cycle with no expectation", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (rdata_a !== e.a) begin
          n_bad++;
          $display("FAIL rdata_a t=%0t: got %h, expected %h", $time, rdata_a, e.a);
        end
        n_cmp++;
        if (rdata_b !== e.b) begin
          n_bad++;
          $display("FAIL rdata_b t=%0t: got %h, expected %h", $time, rdata_b, e.b);
        end
      end
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra, input logic w,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if ((ZERO_REG != 0) && (ra == '0)) return '0;
    if ((BYPASS != 0) && w && (wa == ra)) return wd;
    return mem_m[ra];
  endfunction

  // One clock of stimulus: drive, check wsel, push expectation, update model.
  task automatic drive(input logic r, input logic w, input int wa, input logic [DW-1:0] wd,
                       input logic e, input int ra, input int rb);
    logic [AW-1:0]    wa_l, ra_l, rb_l;
    logic [NREGS-1:0] ws_exp;
    exp_t             x;
    wa_l = AW'(wa);
    ra_l = AW'(ra);
    rb_l = AW'(rb);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa_l; wdata = wd; re = e; raddr_a = ra_l; raddr_b = rb_l;
    issue = 1'b1;
    ws_exp = w ? NREGS'(onehot(MAX_AW'(wa_l))) : '0;
    if (ZERO_REG != 0) ws_exp[0] = 1'b0;
    #1;
    n_cmp++;
    if (wsel !== ws_exp) begin
      n_bad++;
      $display("FAIL wsel t=%0t: got %h, expected %h", $time, wsel, ws_exp);
    end
    if (r) begin
      x.a = '0;
      x.b = '0;
      for (int i = 0; i < NREGS; i++) mem_m[i] = '0;
    end else begin
      if (e) begin
        x.a = model_read(ra_l, w, wa_l, wd);
        x.b = model_read(rb_l, w, wa_l, wd);
      end else begin
        x.a = hold_a;
        x.b = hold_b;
      end
      if (w && !((ZERO_REG != 0) && (wa_l == '0))) mem_m[wa_l] = wd;
    end
    hold_a = x.a;
    hold_b = x.b;
    exp_q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) mem_m[i] = '0;

    // Reset, preload random data, pulse reset while reading, read all back as zero.
    drive(1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    for (int i = 0; i < NREGS; i++) drive(1'b0, 1'b1, i, DW'($urandom), 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 9, 10);
    drive(1'b1, 1'b0, 0, '0, 1'b1, 9, 10);
    for (int i = 0; i < NREGS; i += 2) drive(1'b0, 1'b0, 0, '0, 1'b1, i, i + 1);

    // Plain write then read.
    drive(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 5, 6);

    // Same-edge bypass on both ports.
    drive(1'b0, 1'b1, 7, 32'h0000_1111, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 7, 32'h0000_2222, 1'b1, 7, 7);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 7, 5);

    // Zero register: write suppressed, reads stay zero even with bypass.
    drive(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 0, 0);
    drive(1'b0, 1'b1, 0, 32'h1234_5678, 1'b1, 0, 5);

    // Hold with re=0 while addresses and writes change.
    drive(1'b0, 1'b0, 0, '0, 1'b1, 5, 7);
    drive(1'b0, 1'b0, 0, '0, 1'b0, 1, 2);
    drive(1'b0, 1'b1, 5, 32'hCAFE_F00D, 1'b0, 5, 7);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 5, 7);

    // Reset beats a coincident write.
    drive(1'b0, 1'b1, 3, 32'h0000_005A, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 3, 32'h0000_00A5, 1'b1, 3, 3);
    drive(1'b0, 1'b0, 0, '0, 1'b1, 3, 5);

    // Sweep: addr i gets i+1, read back on both ports in opposite order.
    for (int i = 0; i < NREGS; i++) drive(1'b0, 1'b1, i, DW'(i + 1), 1'b0, 0, 0);
    for (int i = 0; i < NREGS; i++) drive(1'b0, 1'b0, 0, '0, 1'b1, i, NREGS - 1 - i);

    @(posedge clk);
    #1;
    issue = 1'b0; we = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
